// File: rtl/seg_scan_driver_pkg.sv
// Shared display constants and helpers for the segment scan driver
// and the other display blocks.
package seg_scan_driver_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int MAX_DIGITS = 8;

  // Callers truncate the result to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(
    input logic [2:0] idx
  );
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_scan_driver_slot_counter.sv
// Slot/digit counter for the segment scanner: walks cnt within a slot
// and idx across digits, and flags slot/frame starts and blanking.
module scan_slot_counter
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 5000,
  parameter int BLANK_CYCLES = 250,
  parameter int CW = $clog2(SCAN_DIV),
  parameter int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENABLE,
  output logic [IW-1:0] idx,
  output logic          slot_start,
  output logic          frame_start,
  output logic          in_blank
);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || !ENABLE) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      if (idx == IW'(NUM_DIGITS - 1))
        idx <= '0;
      else
        idx <= idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_start  = (cnt == '0);
  assign frame_start = slot_start && (idx == '0);
  assign in_blank    = (cnt < CW'(BLANK_CYCLES));

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: snapshots all digit patterns once
// per frame and lights one digit per slot after a blanking interval.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 5000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic [8*NUM_DIGITS-1:0] SEG_IN,
  output logic [7:0]              SEG_OUT,
  output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
  output logic                    FRAME_TICK
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IW-1:0]           idx;
  logic                    slot_start;
  logic                    frame_start;
  logic                    in_blank;
  logic                    take;
  logic [8*NUM_DIGITS-1:0] snap;

  scan_slot_counter #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_cnt (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .idx         (idx),
    .slot_start  (slot_start),
    .frame_start (frame_start),
    .in_blank    (in_blank)
  );

  assign take = slot_start && frame_start;

  // The snapshot lands in slot 0's blank window, so no torn pattern shows.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap       <= '0;
      SEG_OUT    <= SEG_BLANK;
      DIGIT_SEL  <= '0;
      FRAME_TICK <= 1'b0;
    end else if (!ENABLE) begin
      SEG_OUT    <= SEG_BLANK;
      DIGIT_SEL  <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= take;
      if (take)
        snap <= SEG_IN;
      if (in_blank) begin
        SEG_OUT   <= SEG_BLANK;
        DIGIT_SEL <= '0;
      end else begin
        SEG_OUT   <= snap[{idx, 3'b000} +: 8];
        DIGIT_SEL <= NUM_DIGITS'(digit_onehot(3'(idx)));
      end
    end
  end

endmodule
